// File: rtl/keccak_pkg.sv
// Shared Keccak constants: mode encoding, rates and digest lengths.
// Imported by the input padder and by the output squeezer.
package keccak_pkg;

  localparam int LANE_W   = 64;
  localparam int MAX_RATE = 21;
  localparam int CNT_W    = 16;
  localparam int IDX_W    = $clog2(MAX_RATE);

  localparam logic [1:0] MODE_SHA3_512 = 2'd0;
  localparam logic [1:0] MODE_SHA3_256 = 2'd1;
  localparam logic [1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [1:0] MODE_SHAKE256 = 2'd3;

  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  localparam int DIGEST_SHA3_512 = 8;
  localparam int DIGEST_SHA3_256 = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PERM,
    S_EMIT
  } sq_state_e;

  function automatic logic [IDX_W-1:0] rate_of(
    input logic [1:0] m
  );
    logic [IDX_W-1:0] r;
    r = IDX_W'(RATE_SHAKE256);
    unique case (m)
      MODE_SHA3_512: r = IDX_W'(RATE_SHA3_512);
      MODE_SHA3_256: r = IDX_W'(RATE_SHA3_256);
      MODE_SHAKE128: r = IDX_W'(RATE_SHAKE128);
      MODE_SHAKE256: r = IDX_W'(RATE_SHAKE256);
      default:       r = IDX_W'(RATE_SHAKE256);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keccak_squeezer.sv
// Keccak squeeze stage: captures the rate lanes after a permutation
// and streams them out, requesting more permutations for XOF modes.
module keccak_squeezer #(
  parameter int LANE_W   = 64,
  parameter int MAX_RATE = 21,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              squeeze_start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  out_words,
  input  logic [1599:0]     state_in,
  input  logic              perm_done,
  output logic              perm_req,
  output logic [LANE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  import keccak_pkg::*;

  localparam int IW = $clog2(MAX_RATE);

  sq_state_e         state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LANE_W-1:0] buf_q [MAX_RATE];
  logic [LANE_W-1:0] buf_d [MAX_RATE];
  logic [LANE_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  total;
  logic [IW-1:0]     last_idx;
  logic              hs;
  logic              unused_state;

  assign unused_state = ^state_in[1599:MAX_RATE*LANE_W];

  assign perm_req  = req_q;
  assign out       = out_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign hs        = vld_q & out_ready;
  assign last_idx  = IW'(rate_of(mode_q)) - IW'(1);

  // Digest length in lanes for the mode presented with squeeze_start.
  always_comb begin
    total = CNT_W'(1);
    unique case (mode)
      MODE_SHA3_512: total = CNT_W'(DIGEST_SHA3_512);
      MODE_SHA3_256: total = CNT_W'(DIGEST_SHA3_256);
      default: begin
        total = (out_words == '0) ? CNT_W'(1) : out_words;
      end
    endcase
  end

  // Next-state, buffer capture and registered output lane selection.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    out_d   = out_q;
    vld_d   = vld_q;
    last_d  = last_q;
    req_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (squeeze_start) begin
          state_d = S_WAIT_PERM;
          mode_d  = mode;
          rem_d   = total;
          idx_d   = '0;
        end
      end
      S_WAIT_PERM: begin
        if (perm_done) begin
          for (int i = 0; i < MAX_RATE; i++) begin
            buf_d[i] = state_in[i*LANE_W +: LANE_W];
          end
          state_d = S_EMIT;
          idx_d   = '0;
          out_d   = state_in[LANE_W-1:0];
          vld_d   = 1'b1;
          last_d  = (rem_q == CNT_W'(1));
        end
      end
      S_EMIT: begin
        if (hs) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else if (idx_q == last_idx) begin
            state_d = S_WAIT_PERM;
            req_d   = 1'b1;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IW'(1);
            out_d  = buf_q[idx_q + IW'(1)];
            last_d = (rem_q == CNT_W'(2));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, buffer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      req_q   <= 1'b0;
      for (int i = 0; i < MAX_RATE; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_keccak_squeezer.sv
// Directed and randomized bench for keccak_squeezer with a lane
// sequence model built from rate and digest-length rules.
module tb_keccak_squeezer;

  logic          clk = 1'b0;
  logic          rst;
  logic          squeeze_start;
  logic [1:0]    mode;
  logic [15:0]   out_words;
  logic [1599:0] state_in;
  logic          perm_done;
  logic          perm_req;
  logic [63:0]   out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int preq_cnt = 0;

  keccak_squeezer dut (
    .clk(clk), .rst(rst),
    .squeeze_start(squeeze_start), .mode(mode),
    .out_words(out_words), .state_in(state_in),
    .perm_done(perm_done), .perm_req(perm_req),
    .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (perm_req === 1'b1) preq_cnt++;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rate_m(int m);
    case (m)
      0: return 9;
      1: return 17;
      2: return 21;
      default: return 17;
    endcase
  endfunction

  function automatic int total_m(int m, int w);
    if (m == 0) return 8;
    if (m == 1) return 4;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [1599:0] rnd_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // stall: 0 always ready, 1 pattern 1,0,0, 2 random
  // pat: lanes are 0x1000+i instead of random
  // inject: spurious start/perm_done during EMIT
  // rst_at: assert reset once this many lanes were taken
  task automatic run(int md, int words, int stall, bit pat,
                     bit inject, int rst_at);
    int total, rate, k, blk_end, budget, cyc, p0, n_blk;
    logic [1599:0] st;
    bit r, injected;
    total = total_m(md, words);
    rate = rate_m(md);
    n_blk = (total + rate - 1) / rate;
    k = 0; cyc = 0; injected = 0;
    p0 = preq_cnt;
    @(negedge clk);
    mode = 2'(md);
    out_words = 16'(words);
    squeeze_start = 1'b1;
    @(negedge clk);
    squeeze_start = 1'b0;
    mode = 2'($urandom);
    out_words = 16'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("no_valid_waiting", 64'(out_valid), 64'd0);
    while (k < total) begin
      st = rnd_state();
      if (pat) for (int i = 0; i < 25; i++)
        st[64*i +: 64] = 64'h1000 + 64'(i);
      state_in = st;
      perm_done = 1'b1;
      @(negedge clk);
      perm_done = 1'b0;
      state_in = rnd_state();
      chk("first_lane_latency", 64'(out_valid), 64'd1);
      blk_end = (k / rate + 1) * rate;
      if (blk_end > total) blk_end = total;
      budget = 0;
      while (k < blk_end && budget < 1000) begin
        budget++;
        chk("lane_valid", 64'(out_valid), 64'd1);
        chk("lane_data", out, st[64*(k % rate) +: 64]);
        chk("lane_last", 64'(out_last),
            64'(k == total - 1));
        chk("no_req_emit", 64'(perm_req), 64'd0);
        if (rst_at >= 0 && k == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_valid", 64'(out_valid), 64'd0);
          chk("rst_req", 64'(perm_req), 64'd0);
          chk("rst_last", 64'(out_last), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_out", out, 64'd0);
          @(negedge clk);
          rst = 1'b0;
          out_ready = 1'b0;
          return;
        end
        case (stall)
          0: r = 1'b1;
          1: r = (cyc % 3 == 0);
          default: r = 1'($urandom);
        endcase
        cyc++;
        if (inject && k == 1 && !injected) begin
          r = 1'b0;
          injected = 1'b1;
          squeeze_start = 1'b1;
          perm_done = 1'b1;
          mode = 2'd2;
          out_words = 16'd99;
        end
        out_ready = r;
        @(negedge clk);
        squeeze_start = 1'b0;
        perm_done = 1'b0;
        if (r) k++;
      end
      if (budget >= 1000) begin
        chk("lane_budget", 64'd0, 64'd1);
        return;
      end
      if (k < total) begin
        chk("req_pulse", 64'(perm_req), 64'd1);
        chk("req_valid_low", 64'(out_valid), 64'd0);
        chk("req_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("req_one_cycle", 64'(perm_req), 64'd0);
      end
    end
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_last", 64'(out_last), 64'd0);
    chk("req_count", 64'(preq_cnt - p0), 64'(n_blk - 1));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    squeeze_start = 1'b0;
    mode = 2'd0;
    out_words = 16'd0;
    state_in = '0;
    perm_done = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_req", 64'(perm_req), 64'd0);
    chk("reset_last", 64'(out_last), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_out", out, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    state_in = rnd_state();
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    @(negedge clk);
    chk("idle_perm_valid", 64'(out_valid), 64'd0);
    chk("idle_perm_busy", 64'(busy), 64'd0);

    run(0, 0, 0, 1'b1, 1'b0, -1);
    run(1, 0, 1, 1'b1, 1'b0, -1);
    run(2, 25, 0, 1'b0, 1'b0, -1);
    run(3, 0, 0, 1'b0, 1'b0, -1);
    run(1, 0, 0, 1'b0, 1'b1, -1);
    run(3, 10, 0, 1'b0, 1'b0, 4);
    run(3, 10, 2, 1'b0, 1'b0, -1);
    run(2, 43, 2, 1'b0, 1'b1, -1);
    for (int i = 0; i < 5; i++) begin
      run(int'($urandom_range(0, 3)),
          int'($urandom_range(0, 45)), 2,
          1'b0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
